// File: rtl/conv_pkg.sv
// Shared definitions for the conv_sequencer frame controller.
// Holds the FSM state encoding and helpers that derive the frame item counts
// (weights, pixels, results) from the convolution geometry.
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } state_e;

  // Number of kernel weights per frame.
  function automatic int unsigned calc_w_nb(input int unsigned kernel_size);
    return kernel_size * kernel_size;
  endfunction

  // Number of input pixels per frame.
  function automatic int unsigned calc_p_nb(input int unsigned data_size);
    return data_size * data_size;
  endfunction

  // Number of output results per frame.
  function automatic int unsigned calc_out_nb(input int unsigned data_size,
                                              input int unsigned kernel_size,
                                              input int unsigned stride);
    int unsigned edge_len;
    edge_len = (data_size - kernel_size) / stride + 1;
    return edge_len * edge_len;
  endfunction

endpackage

// File: rtl/conv_sequencer.sv
// Frame-level controller in front of the conv_simple datapath.
// Accepts one start command per frame, loads the kernel weights, streams one
// frame of pixels and forwards/counts the datapath results until the full
// output map has been seen, then pulses o_done.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   i_start                    one-cycle frame start (sampled in IDLE only)
//   i_wdata/i_wvalid/o_wready  weight stream (row-major)
//   i_pdata/i_pvalid/o_pready  pixel stream (raster order)
//   o_x/o_valid                pixel to datapath
//   o_w/o_addr/o_w_en          weight write port to datapath
//   i_conv_y/i_conv_valid      datapath result
//   o_y/o_y_valid              forwarded result
//   o_busy/o_done              status, frame-complete pulse
module conv_sequencer
  import conv_pkg::*;
#(
  parameter int unsigned KERNEL_SIZE = 5,
  parameter int unsigned DATA_SIZE   = 32,
  parameter int unsigned STRIDE      = 1,
  parameter int unsigned DATA_BW     = 8,
  parameter int unsigned WEIGHT_BW   = 8,
  parameter int unsigned ADDR_BW     = 5,
  parameter int unsigned SUM_BW      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_start,
  input  logic [WEIGHT_BW-1:0] i_wdata,
  input  logic                 i_wvalid,
  output logic                 o_wready,
  input  logic [DATA_BW-1:0]   i_pdata,
  input  logic                 i_pvalid,
  output logic                 o_pready,
  output logic [DATA_BW-1:0]   o_x,
  output logic                 o_valid,
  output logic [WEIGHT_BW-1:0] o_w,
  output logic [ADDR_BW-1:0]   o_addr,
  output logic                 o_w_en,
  input  logic [SUM_BW-1:0]    i_conv_y,
  input  logic                 i_conv_valid,
  output logic [SUM_BW-1:0]    o_y,
  output logic                 o_y_valid,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int unsigned W_NB    = calc_w_nb(KERNEL_SIZE);
  localparam int unsigned P_NB    = calc_p_nb(DATA_SIZE);
  localparam int unsigned OUT_NB  = calc_out_nb(DATA_SIZE, KERNEL_SIZE, STRIDE);
  localparam int unsigned WCNT_BW = $clog2(W_NB + 1);
  localparam int unsigned PCNT_BW = $clog2(P_NB + 1);

  state_e               r_state;
  state_e               w_next;
  logic [WCNT_BW-1:0]   r_wcnt;
  logic [PCNT_BW-1:0]   r_pcnt;
  logic [PCNT_BW-1:0]   r_rcnt;
  logic                 r_wready;
  logic                 r_pready;
  logic                 w_start;
  logic                 w_whs;
  logic                 w_phs;
  logic                 w_racc;
  logic                 w_wlast;
  logic                 w_plast;
  logic                 w_rfull;

  // Handshakes and last-item detection.
  assign w_start = (r_state == IDLE) & i_start;
  assign w_whs   = (r_state == LOAD_W) & i_wvalid;
  assign w_phs   = (r_state == STREAM) & i_pvalid;
  assign w_wlast = w_whs & (r_wcnt == WCNT_BW'(W_NB - 1));
  assign w_plast = w_phs & (r_pcnt == PCNT_BW'(P_NB - 1));
  assign w_rfull = (r_rcnt == PCNT_BW'(OUT_NB));
  // Results only count while the frame is streaming or draining, up to OUT_NB.
  assign w_racc  = i_conv_valid & ~w_rfull &
                   ((r_state == STREAM) | (r_state == DRAIN));

  // Readies are flops loaded from the next state, so they equal a decode of the state.
  assign o_wready = r_wready;
  assign o_pready = r_pready;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // FSM next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_start) w_next = LOAD_W;
      LOAD_W:  if (w_wlast) w_next = STREAM;
      STREAM:  if (w_plast) w_next = DRAIN;
      DRAIN:   if (w_rfull) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Weight, pixel and result counters; all cleared when a frame starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wcnt <= '0;
      r_pcnt <= '0;
      r_rcnt <= '0;
    end else if (w_start) begin
      r_wcnt <= '0;
      r_pcnt <= '0;
      r_rcnt <= '0;
    end else begin
      if (w_whs)  r_wcnt <= r_wcnt + WCNT_BW'(1);
      if (w_phs)  r_pcnt <= r_pcnt + PCNT_BW'(1);
      if (w_racc) r_rcnt <= r_rcnt + PCNT_BW'(1);
    end
  end

  // Status flags registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wready <= 1'b0;
      r_pready <= 1'b0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
    end else begin
      r_wready <= (w_next == LOAD_W);
      r_pready <= (w_next == STREAM);
      o_busy   <= (w_next != IDLE);
      o_done   <= (w_next == DONE);
    end
  end

  // Datapath strobes, one cycle behind their handshakes; data holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_w       <= '0;
      o_addr    <= '0;
      o_w_en    <= 1'b0;
      o_x       <= '0;
      o_valid   <= 1'b0;
      o_y       <= '0;
      o_y_valid <= 1'b0;
    end else begin
      o_w_en    <= w_whs;
      o_valid   <= w_phs;
      o_y_valid <= w_racc;
      if (w_whs) begin
        o_w    <= i_wdata;
        o_addr <= ADDR_BW'(r_wcnt);
      end
      if (w_phs)  o_x <= i_pdata;
      if (w_racc) o_y <= i_conv_y;
    end
  end

endmodule

// File: doc/conv_sequencer.md
# conv_sequencer

Frame-level controller placed in front of the `conv_simple` convolution datapath. It accepts a start command, loads the KERNEL_SIZE² weights from a valid/ready weight stream into the datapath, then streams one DATA_SIZE×DATA_SIZE frame of pixels from a valid/ready pixel stream. It forwards and counts the datapath results and signals `o_done` once the full output map has been received, so a host or DMA sees one command per frame.

## Interface
- KERNEL_SIZE, 5, kernel edge length.
- DATA_SIZE, 32, input frame edge length.
- STRIDE, 1, convolution stride; `(DATA_SIZE-KERNEL_SIZE)` must be divisible by STRIDE.
- DATA_BW, 8, pixel width.
- WEIGHT_BW, 8, weight width.
- ADDR_BW, 5, weight address width; must hold KERNEL_SIZE²-1.
- SUM_BW, 16, result width.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_start  in  1  one-cycle start command; sampled only in IDLE.
- i_wdata  in  WEIGHT_BW  weight stream data; row-major order, row 0 col 0 first.
- i_wvalid  in  1  weight data valid.
- o_wready  out  1  weight ready.
- i_pdata  in  DATA_BW  pixel stream data; raster order.
- i_pvalid  in  1  pixel data valid.
- o_pready  out  1  pixel ready.
- o_x  out  DATA_BW  pixel to datapath `i_x`.
- o_valid  out  1  pixel valid to datapath `i_valid`.
- o_w  out  WEIGHT_BW  weight to datapath `i_w`.
- o_addr  out  ADDR_BW  weight address to datapath `i_addr`.
- o_w_en  out  1  weight write strobe to datapath `i_w_en`.
- i_conv_y  in  SUM_BW  datapath result `o_y`.
- i_conv_valid  in  1  datapath result valid `o_valid`.
- o_y  out  SUM_BW  forwarded result.
- o_y_valid  out  1  forwarded result valid.
- o_busy  out  1  high in every state except IDLE.
- o_done  out  1  one-cycle frame-complete pulse.

## Operation
- Constants: W_NB = KERNEL_SIZE², P_NB = DATA_SIZE², OUT_NB = ((DATA_SIZE-KERNEL_SIZE)/STRIDE+1)². Defaults give 25, 1024 and 784.
- States and transitions:
  - IDLE: `i_start` moves the FSM to LOAD_W.
  - LOAD_W: after the W_NB-th weight handshake, move to STREAM.
  - STREAM: after the P_NB-th pixel handshake, move to DRAIN.
  - DRAIN: when the result count reaches OUT_NB, move to DONE.
  - DONE: always returns to IDLE after one cycle.
- Ready signals are combinational from state only: `o_wready` = (state==LOAD_W) and `o_pready` = (state==STREAM).
- Weight handshake (`i_wvalid` & `o_wready`): the next cycle drives `o_w`=`i_wdata`, `o_addr`=weight index, `o_w_en`=1. The index increments from 0 to W_NB-1. `o_w_en` is 0 otherwise.
- Pixel handshake: the next cycle drives `o_x`=`i_pdata` and `o_valid`=1. `o_valid` is 0 on non-handshake cycles; `o_x` holds its last value.
- Results: when `i_conv_valid` is high in STREAM or DRAIN, the next cycle drives `o_y`=`i_conv_y` and `o_y_valid`=1, and the result counter increments.
  - `i_conv_valid` in IDLE, LOAD_W or DONE is dropped and not counted.
  - The result counter saturates at OUT_NB; extra results in DRAIN are dropped.
- Counters (weight, pixel, result) clear on entry to LOAD_W. Pixel and result counters are $clog2(P_NB+1) bits wide.
- `i_start` while busy is ignored. There is no abort; rst_n is the only way to cancel a frame.

## Timing
- Reset values: FSM=IDLE, all counters 0, `o_wready`=`o_pready`=0, `o_x`=`o_w`=`o_addr`=0, `o_w_en`=`o_valid`=0, `o_y`=0, `o_y_valid`=0, `o_busy`=0, `o_done`=0.
- Reset mid-frame: all of the above apply asynchronously, and no `o_done` is issued.
- Start latency: `i_start` at cycle t puts the FSM in LOAD_W at t+1, so `o_wready` is first high at t+1.
- Datapath strobes (`o_w_en`, `o_valid`) lag their handshake by exactly 1 cycle. Forwarded results lag `i_conv_valid` by exactly 1 cycle.
- Last-item boundaries:
  - The last weight handshake at cycle t gives `o_pready`=1 at t+1, so no bubble beyond the FSM edge.
  - The last pixel handshake at cycle t gives `o_pready`=0 at t+1.
- A result arriving in the same cycle as the last pixel handshake is counted.
- DONE lasts one cycle: `o_done`=1 and `o_busy`=1. The FSM is in IDLE on the next cycle, and a new `i_start` is accepted there.
- Back-pressure: a low `i_wvalid` or `i_pvalid` simply stalls the counters. The datapath sees `o_valid`=0 on those cycles.

## Structure
- Shared package `conv_pkg` holds the FSM state enum (IDLE, LOAD_W, STREAM, DRAIN, DONE) and functions that derive W_NB, P_NB and OUT_NB from the parameters.
- The block is a single module with no sub-modules. Its three counters are plain registers inside the module.

## Test plan
- Reset then idle: `o_busy`=0, both readies 0, and all strobes 0 for 20 cycles, with `i_conv_valid` pulsed and `o_y_valid` staying 0.
- Weight load: `i_start`, then 25 weights with values 1..25 at full rate. Expect 25 `o_w_en` pulses with `o_addr` 0..24 and `o_w` 1..25, and `o_pready`=1 on the cycle after the 25th handshake.
- Pixel stream with gaps: `i_pvalid` toggles 1/0. Expect exactly 1024 `o_valid` pulses, each one cycle after its handshake, with data preserved, and `o_pready`=0 after the 1024th.
- Frame completion: drive 784 `i_conv_valid` pulses, plus 3 extra in DRAIN. Expect 784 `o_y_valid` pulses, a single `o_done` pulse in the cycle after the 784th forwarded result, and then IDLE.
- Start while busy: `i_start` pulsed during STREAM causes no state or counter change. Back-to-back frames work, with a new `i_start` in the cycle after `o_done`.
- Reset mid-STREAM at pixel 500: outputs return to reset values immediately, and a new `i_start` runs a full frame with counters from 0.
